// File: rtl/hazard_unit_mc.sv
// Hazard unit for a 5-stage RISC-V pipeline: forwarding, load-use, control flush,
// multi-cycle execute sequencing, data-memory wait stalling and perf counters.
module hazard_unit_mc #(
  parameter int RA_W   = 5,
  parameter int MC_LAT = 4,
  parameter int MEM_TO = 16,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic [1:0]       ResultSrcM,
  input  logic [1:0]       PCSrcE,
  input  logic [RA_W-1:0]  Rs1D,
  input  logic [RA_W-1:0]  Rs2D,
  input  logic [RA_W-1:0]  Rs1E,
  input  logic [RA_W-1:0]  Rs2E,
  input  logic [RA_W-1:0]  RdE,
  input  logic [RA_W-1:0]  RdM,
  input  logic [RA_W-1:0]  RdW,
  input  logic             McStartE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             McBusy,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam int             MW_W    = $clog2(MEM_TO + 1);
  localparam logic [MW_W-1:0] MW_LAST = MW_W'(MEM_TO - 1);
  localparam logic [7:0]     MC_LOAD = 8'(MC_LAT - 2);

  logic [0:0]      r_state;
  logic [7:0]      r_mc_cnt;
  logic [MW_W-1:0] r_mw_cnt;
  logic            r_mem_err;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_mem_stall;
  logic w_mc_start;
  logic w_mc_stall;
  logic w_e_stall;
  logic w_ctrl;
  logic w_lu_match;
  logic w_load_use;

  function automatic logic [1:0] fwd_sel(
    input logic [RA_W-1:0] rs,
    input logic [RA_W-1:0] rd_m,
    input logic [RA_W-1:0] rd_w,
    input logic            we_m,
    input logic            we_w,
    input logic [1:0]      src_m
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0 && we_m && rs == rd_m && src_m != 2'b01)
      sel = (src_m == 2'b00) ? 2'b10 : 2'b11;
    else if (rs != '0 && we_w && rs == rd_w)
      sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    ForwardAE = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW, ResultSrcM);
    ForwardBE = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW, ResultSrcM);
  end

  assign w_mem_stall = MemReqM && !MemReadyM;
  assign w_mc_start  = (r_state == ST_IDLE) && McStartE && !w_mem_stall;
  assign w_mc_stall  = w_mc_start || ((r_state == ST_BUSY) && r_mc_cnt != 8'd0);
  assign w_e_stall   = w_mem_stall || w_mc_stall;
  assign w_ctrl      = (PCSrcE != 2'b00) && !w_e_stall;
  assign w_lu_match  = (ResultSrcE == 2'b01) && (RdE != '0) &&
                       ((Rs1D == RdE) || (Rs2D == RdE));
  assign w_load_use  = w_lu_match && !w_e_stall && !w_ctrl;

  always_comb begin
    StallF = w_e_stall || w_load_use;
    StallD = w_e_stall || w_load_use;
    StallE = w_e_stall;
    StallM = w_mem_stall;
    FlushD = w_ctrl;
    FlushE = w_ctrl || w_load_use;
    FlushM = w_mc_stall && !w_mem_stall;
    FlushW = w_mem_stall;
  end

  // A finishing op held in E by a memory stall keeps BUSY so it is not restarted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_mc_cnt <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_mc_start) begin
          r_state  <= ST_BUSY;
          r_mc_cnt <= MC_LOAD;
        end
        default: begin
          if (r_mc_cnt != 8'd0) begin
            if (!w_mem_stall) r_mc_cnt <= r_mc_cnt - 8'd1;
          end else if (!w_mem_stall) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mw_cnt  <= '0;
      r_mem_err <= 1'b0;
    end else if (w_mem_stall) begin
      if (r_mw_cnt == MW_LAST) r_mem_err <= 1'b1;
      else                     r_mw_cnt  <= r_mw_cnt + 1'b1;
    end else begin
      r_mw_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (StallF && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (FlushD && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign McBusy   = (r_state == ST_BUSY);
  assign MemErr   = r_mem_err;
  assign StallCnt = r_stall_cnt;
  assign FlushCnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed self-checking bench for hazard_unit_mc with default parameters.
module tb_hazard_unit_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, RegWriteW;
  logic [1:0]  ResultSrcE, ResultSrcM, PCSrcE;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        McStartE, MemReqM, MemReadyM;
  logic        StallF, StallD, StallE, StallM;
  logic        FlushD, FlushE, FlushM, FlushW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        McBusy, MemErr;
  logic [31:0] StallCnt, FlushCnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_unit_mc dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM), .PCSrcE(PCSrcE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .McStartE(McStartE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .McBusy(McBusy), .MemErr(MemErr),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; ResultSrcM = 0; PCSrcE = 0;
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    McStartE = 0; MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic all_comb_zero(input string tag);
    chk({tag, "_stall"}, {28'd0, StallF, StallD, StallE, StallM}, 32'd0);
    chk({tag, "_flush"}, {28'd0, FlushD, FlushE, FlushM, FlushW}, 32'd0);
    chk({tag, "_fwd"}, {28'd0, ForwardAE, ForwardBE}, 32'd0);
  endtask

  initial begin
    idle();
    rst = 1;
    step(); step();
    rst = 0;
    #1;
    all_comb_zero("reset");
    chk("reset_busy", {31'd0, McBusy}, 32'd0);
    chk("reset_err", {31'd0, MemErr}, 32'd0);
    chk("reset_scnt", StallCnt, 32'd0);
    chk("reset_fcnt", FlushCnt, 32'd0);

    // forwarding
    RdM = 5; RegWriteM = 1; ResultSrcM = 2'b00; RdW = 5; RegWriteW = 1; Rs1E = 5;
    #1 chk("fwdA_alu", {30'd0, ForwardAE}, 32'd2);
    ResultSrcM = 2'b11;
    #1 chk("fwdA_imm", {30'd0, ForwardAE}, 32'd3);
    ResultSrcM = 2'b10;
    #1 chk("fwdA_pc4", {30'd0, ForwardAE}, 32'd3);
    Rs1E = 0;
    #1 chk("fwdA_x0", {30'd0, ForwardAE}, 32'd0);
    RdW = 6; Rs2E = 6;
    #1 chk("fwdB_w", {30'd0, ForwardBE}, 32'd1);
    RdM = 6; ResultSrcM = 2'b00;
    #1 chk("fwdB_m_over_w", {30'd0, ForwardBE}, 32'd2);
    idle();

    // load-use
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    #1;
    chk("lu_stall", {29'd0, StallF, StallD, FlushE}, 32'd7);
    chk("lu_noE", {30'd0, StallE, FlushD}, 32'd0);
    step();
    idle();
    #1;
    chk("lu_scnt", StallCnt, 32'd1);
    chk("lu_fcnt", FlushCnt, 32'd0);
    ResultSrcE = 2'b01; RdE = 0; Rs2D = 0;
    #1 chk("lu_x0", {29'd0, StallF, StallD, FlushE}, 32'd0);
    idle();

    // multi-cycle op, MC_LAT=4
    for (int i = 0; i < 4; i++) begin
      McStartE = 1;
      #1;
      chk($sformatf("mc_stallE_%0d", i), {31'd0, StallE}, (i < 3) ? 32'd1 : 32'd0);
      chk($sformatf("mc_flushM_%0d", i), {31'd0, FlushM}, (i < 3) ? 32'd1 : 32'd0);
      chk($sformatf("mc_busy_%0d", i), {31'd0, McBusy}, (i >= 1) ? 32'd1 : 32'd0);
      step();
    end
    McStartE = 0;
    #1;
    chk("mc_idle", {31'd0, McBusy}, 32'd0);
    chk("mc_scnt", StallCnt, 32'd4);

    // short memory wait
    MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mw_stallM_%0d", i), {30'd0, StallM, FlushW}, 32'd3);
      chk($sformatf("mw_noflushDEM_%0d", i), {29'd0, FlushD, FlushE, FlushM}, 32'd0);
      step();
    end
    MemReadyM = 1;
    #1;
    chk("mw_err_short", {31'd0, MemErr}, 32'd0);
    chk("mw_release", {31'd0, StallM}, 32'd0);
    step();
    chk("mw_scnt", StallCnt, 32'd7);

    // memory timeout after 16 waiting cycles
    MemReadyM = 0;
    for (int i = 0; i < 16; i++) begin
      #1 chk($sformatf("to_err_pre_%0d", i), {31'd0, MemErr}, 32'd0);
      step();
    end
    chk("to_err_set", {31'd0, MemErr}, 32'd1);
    idle();
    step(); step();
    chk("to_err_sticky", {31'd0, MemErr}, 32'd1);
    chk("to_scnt", StallCnt, 32'd23);

    // branch with simultaneous load-use
    PCSrcE = 2'b01; ResultSrcE = 2'b01; RdE = 9; Rs1D = 9;
    #1;
    chk("br_flush", {30'd0, FlushD, FlushE}, 32'd3);
    chk("br_nostall", {30'd0, StallF, StallD}, 32'd0);
    step();
    idle();
    #1;
    chk("br_fcnt", FlushCnt, 32'd1);
    chk("br_scnt", StallCnt, 32'd23);

    // branch deferred by memory stall
    PCSrcE = 2'b10; MemReqM = 1; MemReadyM = 0;
    #1;
    chk("brm_noflush", {30'd0, FlushD, FlushE}, 32'd0);
    chk("brm_stall", {31'd0, StallF}, 32'd1);
    step();
    MemReadyM = 1;
    #1 chk("brm_flush", {30'd0, FlushD, FlushE}, 32'd3);
    step();
    idle();
    #1;
    chk("brm_fcnt", FlushCnt, 32'd2);
    chk("brm_scnt", StallCnt, 32'd24);
    all_comb_zero("brm_idle");

    // reset while BUSY with cnt=1
    McStartE = 1;
    step(); step();
    chk("rb_busy", {31'd0, McBusy}, 32'd1);
    rst = 1;
    step();
    rst = 0; idle();
    #1;
    chk("rb_busy_clr", {31'd0, McBusy}, 32'd0);
    chk("rb_scnt", StallCnt, 32'd0);
    chk("rb_fcnt", FlushCnt, 32'd0);
    chk("rb_err", {31'd0, MemErr}, 32'd0);
    all_comb_zero("rb");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
